sn74169_ctrl: RTL and testbench

Command sequencer for the sn74169 4-bit synchronous up/down counter. Accepts LOAD, COUNT-N and COUNT-to-terminal commands over a valid/ready interface and drives the counter's active-low control pins (LOADB, ENPB, ENTB) plus U_DB and A. It monitors Q and RCOB, and reports done, wrap and error status. It sits between the tt_um top level and the sn74169 instance, on the same clock.

---
 rtl/sn74169_pkg.sv | 27 ++
 rtl/sn74169_ctrl_if.sv | 33 +++
 rtl/sn74169_ctrl_timer.sv | 22 ++
 rtl/sn74169_ctrl.sv | 148 ++++++++++++++
 tb/tb_sn74169_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sn74169_pkg.sv
// Shared encodings for the sn74169 command sequencer: op codes, FSM states,
// terminal-count values and the step-count preload helper.
package sn74169_pkg;

  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_COUNT_N  = 2'b10;
  localparam logic [1:0] OP_COUNT_TC = 2'b11;

  localparam logic [3:0] TC_UP = 4'hF;
  localparam logic [3:0] TC_DN = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COUNT_N,
    ST_COUNT_TC,
    ST_DONE
  } state_e;

  // The timer completes on its zero flag, so it is preloaded with N-1
  // (a step count of 0 means 16).
  function automatic logic [7:0] steps_m1(input logic [3:0] d);
    return (d == 4'd0) ? 8'd15 : ({4'd0, d} - 8'd1);
  endfunction

endpackage

// File: rtl/sn74169_ctrl_if.sv
// Command and counter-pin bundle between the sequencer (slave) and its
// environment: command source, sn74169 instance and status consumer (master).
interface sn74169_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [3:0] cmd_data;
  logic [3:0] ctr_a;
  logic       ctr_loadb;
  logic       ctr_enpb;
  logic       ctr_entb;
  logic       ctr_udb;
  logic [3:0] ctr_q;
  logic       ctr_rcob;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       err;
  logic [3:0] q_snap;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_data, ctr_q, ctr_rcob,
    output cmd_ready, ctr_a, ctr_loadb, ctr_enpb, ctr_entb, ctr_udb,
           busy, done, wrap, err, q_snap
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_data, ctr_q, ctr_rcob,
    input  cmd_ready, ctr_a, ctr_loadb, ctr_enpb, ctr_entb, ctr_udb,
           busy, done, wrap, err, q_snap
  );
endinterface

// File: rtl/sn74169_ctrl_timer.sv
// Loadable 8-bit down-counter with zero flag; shared by the COUNT_N step
// count and the COUNT_TC timeout.
module sn74169_ctrl_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_cnt <= 8'd0;
    else if (i_load)                   r_cnt <= i_val;
    else if (i_dec && r_cnt != 8'd0)   r_cnt <= r_cnt - 8'd1;
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/sn74169_ctrl.sv
// Command sequencer driving an sn74169 up/down counter (LOAD, COUNT_N,
// COUNT_TC). Optional abort input when SN74169_CTRL_ABORT_EN is defined.
module sn74169_ctrl
  import sn74169_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SN74169_CTRL_ABORT_EN
  input  logic abort,
`endif
  sn74169_ctrl_if.slave bus
);

  state_e     r_state;
  logic [3:0] r_a, r_q_snap;
  logic       r_loadb, r_enpb, r_entb, r_udb;
  logic       r_busy, r_done, r_wrap, r_err;

  logic       w_abort, w_accept, w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [7:0] w_tmr_val;

`ifdef SN74169_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign bus.cmd_ready = (r_state == ST_IDLE) && !w_abort;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = 8'(TIMEOUT - 1);
    if (w_accept && bus.cmd_op == OP_COUNT_N) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = steps_m1(bus.cmd_data);
    end else if (w_accept && bus.cmd_op == OP_COUNT_TC) begin
      w_tmr_load = 1'b1;
    end
  end

  assign w_tmr_dec = (r_state == ST_COUNT_N) || (r_state == ST_COUNT_TC);

  sn74169_ctrl_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .i_dec  (w_tmr_dec),
    .o_zero (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= 4'd0;
      r_loadb  <= 1'b1;
      r_enpb   <= 1'b1;
      r_entb   <= 1'b1;
      r_udb    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
      r_q_snap <= 4'd0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept && bus.cmd_op != OP_NOP) begin
        r_wrap <= 1'b0;
        r_err  <= 1'b0;
        r_busy <= 1'b1;
        case (bus.cmd_op)
          OP_LOAD: begin
            r_a     <= bus.cmd_data;
            r_loadb <= 1'b0;
            r_state <= ST_LOAD;
          end
          OP_COUNT_N: begin
            r_enpb  <= 1'b0;
            r_entb  <= 1'b0;
            r_udb   <= bus.cmd_dir;
            r_state <= ST_COUNT_N;
          end
          default: begin
            r_enpb  <= 1'b0;
            r_entb  <= 1'b0;
            r_udb   <= bus.cmd_dir;
            r_state <= ST_COUNT_TC;
          end
        endcase
      end
    end else if (w_abort) begin
      // Abort beats completion; wrap/err keep their previous values.
      r_state <= ST_IDLE;
      r_loadb <= 1'b1;
      r_enpb  <= 1'b1;
      r_entb  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_loadb <= 1'b1;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_COUNT_N: begin
          if (w_tmr_zero) begin
            r_enpb  <= 1'b1;
            r_entb  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_COUNT_TC: begin
          // RCOB low means the counter wraps on this very edge.
          if (!bus.ctr_rcob || w_tmr_zero) begin
            r_wrap  <= !bus.ctr_rcob;
            r_err   <= bus.ctr_rcob;
            r_enpb  <= 1'b1;
            r_entb  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_done   <= 1'b0;
          r_q_snap <= bus.ctr_q;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ctr_a     = r_a;
  assign bus.ctr_loadb = r_loadb;
  assign bus.ctr_enpb  = r_enpb;
  assign bus.ctr_entb  = r_entb;
  assign bus.ctr_udb   = r_udb;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wrap      = r_wrap;
  assign bus.err       = r_err;
  assign bus.q_snap    = r_q_snap;

endmodule

// File: tb/tb_sn74169_ctrl.sv
// Directed bench for sn74169_ctrl with a behavioural sn74169 counter model;
// the abort steps are built only when SN74169_CTRL_ABORT_EN is defined.
module tb_sn74169_ctrl;
  import sn74169_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic force_rcob = 1'b0;
  logic [3:0] m_q = 4'd0;
  int nvec = 0;
  int nerr = 0;
  int cyc;

  sn74169_ctrl_if bus ();

  sn74169_ctrl #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SN74169_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // sn74169 model: synchronous load, count when both enables low.
  always @(posedge clk) begin
    if (!bus.ctr_loadb)                      m_q <= bus.ctr_a;
    else if (!bus.ctr_enpb && !bus.ctr_entb) m_q <= bus.ctr_udb ? m_q + 4'd1 : m_q - 4'd1;
  end
  assign bus.ctr_q    = m_q;
  assign bus.ctr_rcob = force_rcob |
    !(!bus.ctr_entb && ((bus.ctr_udb && m_q == TC_UP) || (!bus.ctr_udb && m_q == TC_DN)));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic dir, input logic [3:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dir   = dir;
    bus.cmd_data  = data;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Cycles from acceptance until done is seen high, bounded.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!bus.done && n < 64) begin
      step();
      n++;
    end
    if (!bus.done) chk({tag, "_timeout"}, 8'd0, 8'd1);
  endtask

  task automatic load(input logic [3:0] v);
    send(OP_LOAD, 1'b0, v);
    wait_done("load", cyc);
    step();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_dir   = 1'b0;
    bus.cmd_data  = 4'd0;
    repeat (3) step();

    chk("rst_loadb", bus.ctr_loadb, 1);
    chk("rst_enpb",  bus.ctr_enpb,  1);
    chk("rst_entb",  bus.ctr_entb,  1);
    chk("rst_udb",   bus.ctr_udb,   1);
    chk("rst_a",     bus.ctr_a,     0);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_done",  bus.done,      0);
    chk("rst_wrap",  bus.wrap,      0);
    chk("rst_err",   bus.err,       0);
    chk("rst_qsnap", bus.q_snap,    0);
    chk("rst_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    step();

    // LOAD 9
    send(OP_LOAD, 1'b0, 4'd9);
    chk("ld_loadb_lo", bus.ctr_loadb, 0);
    chk("ld_a",        bus.ctr_a,     9);
    chk("ld_busy",     bus.busy,      1);
    chk("ld_ready_lo", bus.cmd_ready, 0);
    step();
    chk("ld_q",        bus.ctr_q,     9);
    chk("ld_done",     bus.done,      1);
    chk("ld_loadb_hi", bus.ctr_loadb, 1);
    step();
    chk("ld_done_lo",  bus.done,      0);
    chk("ld_qsnap",    bus.q_snap,    9);
    chk("ld_ready",    bus.cmd_ready, 1);
    chk("ld_wrap",     bus.wrap,      0);
    chk("ld_err",      bus.err,       0);

    // COUNT_N up 3 from 9
    send(OP_COUNT_N, 1'b1, 4'd3);
    chk("cn3_enpb", bus.ctr_enpb, 0);
    chk("cn3_udb",  bus.ctr_udb,  1);
    step();
    chk("cn3_q1",   bus.ctr_q, 10);
    chk("cn3_d1",   bus.done,  0);
    step();
    chk("cn3_q2",   bus.ctr_q, 11);
    step();
    chk("cn3_q3",   bus.ctr_q, 12);
    chk("cn3_done", bus.done,  1);
    chk("cn3_en",   bus.ctr_enpb, 1);
    step();
    chk("cn3_qsnap", bus.q_snap, 12);
    chk("cn3_hold",  bus.ctr_q,  12);

    // COUNT_N down 16 from 5
    load(4'd5);
    send(OP_COUNT_N, 1'b0, 4'd0);
    wait_done("cn16", cyc);
    chk("cn16_lat", 8'(cyc), 16);
    chk("cn16_q",   bus.ctr_q, 5);
    step();
    chk("cn16_qsnap", bus.q_snap, 5);

    // COUNT_TC up from 13
    load(4'd13);
    send(OP_COUNT_TC, 1'b1, 4'd0);
    wait_done("tc", cyc);
    chk("tc_lat",  8'(cyc), 3);
    chk("tc_q",    bus.ctr_q, TC_DN);
    chk("tc_wrap", bus.wrap, 1);
    chk("tc_err",  bus.err,  0);
    step();
    send(OP_LOAD, 1'b0, 4'd4);
    chk("tc_wrap_clr", bus.wrap, 0);
    wait_done("ld4", cyc);
    step();

    // COUNT_TC timeout with RCOB stuck high
    force_rcob = 1'b1;
    send(OP_COUNT_TC, 1'b1, 4'd0);
    wait_done("to", cyc);
    chk("to_lat",  8'(cyc), 16);
    chk("to_err",  bus.err,  1);
    chk("to_wrap", bus.wrap, 0);
    chk("to_enpb", bus.ctr_enpb, 1);
    chk("to_entb", bus.ctr_entb, 1);
    chk("to_q",    bus.ctr_q, 4);
    force_rcob = 1'b0;
    step();

    // NOP: no done, status untouched
    send(OP_NOP, 1'b1, 4'd7);
    chk("nop_busy", bus.busy, 0);
    chk("nop_done", bus.done, 0);
    step();
    chk("nop_done2", bus.done, 0);
    chk("nop_err",   bus.err,  1);

`ifdef SN74169_CTRL_ABORT_EN
    load(4'd2);
    send(OP_COUNT_N, 1'b1, 4'd10);
    repeat (3) step();
    abort = 1'b1;
    step();
    chk("ab_ready_lo", bus.cmd_ready, 0);
    abort = 1'b0;
    #1;
    chk("ab_ready", bus.cmd_ready, 1);
    chk("ab_q",     bus.ctr_q, 6);
    chk("ab_enpb",  bus.ctr_enpb, 1);
    chk("ab_busy",  bus.busy, 0);
    chk("ab_done",  bus.done, 0);
    repeat (3) step();
    chk("ab_q_hold", bus.ctr_q, 6);
    chk("ab_done2",  bus.done, 0);
`endif

    // Asynchronous reset in the middle of COUNT_N
    load(4'd2);
    send(OP_COUNT_N, 1'b1, 4'd8);
    repeat (3) step();
    chk("mr_q_pre", bus.ctr_q, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_enpb",  bus.ctr_enpb, 1);
    chk("mr_entb",  bus.ctr_entb, 1);
    chk("mr_busy",  bus.busy, 0);
    chk("mr_a",     bus.ctr_a, 0);
    chk("mr_qsnap", bus.q_snap, 0);
    chk("mr_ready", bus.cmd_ready, 1);
    repeat (2) step();
    chk("mr_q_hold", bus.ctr_q, 5);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
